// File: rtl/mwc_pkg.sv
// Shared types for the memory write checker: FSM states, fail codes, index-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mwc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_UNEXPECTED = 3'd1;
  localparam logic [2:0] FC_ORDER      = 3'd2;
  localparam logic [2:0] FC_DUP        = 3'd3;
  localparam logic [2:0] FC_TIMEOUT    = 3'd4;

  // Index width for an n-entry table; a single-entry table still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Data-memory store port as seen by the checker (MemWrite, dataadr, WriteData).
// Latency: n/a (wires only).
// Backpressure: none; the checker is a passive observer and never stalls the store.
// Ports: master drives mem_we/mem_addr/mem_wdata, slave observes them.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mwc_exp_table.sv
// Expected-store register file with a write port and a parallel compare against one store.
// Latency: writes land on the next clock; compare outputs are combinational.
// Backpressure: none; writes with wr_idx >= NUM_EXP are silently dropped.
// Ports: wr_* load one entry; cmp_* is the store under test; matched is the consumed-entry
//   bitmap; hit flags every equal entry; free_hit/free_idx give the lowest unconsumed hit.
module mwc_exp_table
  import mwc_pkg::*;
#(
  parameter int  NUM_EXP = 4,
  parameter int  ADDR_W  = 32,
  parameter int  DATA_W  = 32,
  localparam int IDX_W   = idx_width(NUM_EXP)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0]  cmp_addr,
  input  logic [DATA_W-1:0]  cmp_data,
  input  logic [NUM_EXP-1:0] matched,
  output logic [NUM_EXP-1:0] hit,
  output logic               free_hit,
  output logic [IDX_W-1:0]   free_idx
);

  logic [ADDR_W-1:0] tbl_addr [NUM_EXP];
  logic [DATA_W-1:0] tbl_data [NUM_EXP];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (wr_en) begin
      // Decoding only the real entries drops out-of-range indices for free.
      for (int i = 0; i < NUM_EXP; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          tbl_addr[i] <= wr_addr;
          tbl_data[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    hit      = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      hit[i] = (tbl_addr[i] == cmp_addr) && (tbl_data[i] == cmp_data);
    end
    // Walk downwards so the lowest unconsumed hit is the one left standing.
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      if (hit[i] && !matched[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor: matches observed data-memory stores against a table of expected stores.
// Latency: status registered; done/pass/fail_* assert the cycle after the deciding store.
// Backpressure: none; stores are sampled every cycle mem_we is high and never stalled.
// Ports: clk/reset (async active-low); cfg_* load the table outside RUN; ign_base/ign_mask
//   define scratch stores to skip; start clears status and enters RUN; mem is the observed
//   store port; done/pass/fail_code/fail_addr/fail_data/match_cnt/cycle_cnt report status.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int  ADDR_W  = 32,
  parameter int  DATA_W  = 32,
  parameter int  NUM_EXP = 4,
  parameter int  ORDERED = 1,
  parameter int  TIMEOUT = 1000,
  localparam int IDX_W   = idx_width(NUM_EXP),
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic [ADDR_W-1:0]     ign_base,
  input  logic [ADDR_W-1:0]     ign_mask,
  input  logic                  start,
  mem_write_checker_if.slave    mem,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            fail_code,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [DATA_W-1:0]     fail_data,
  output logic [IDX_W:0]        match_cnt,
  output logic [CNT_W-1:0]      cycle_cnt
);

  state_t             state;
  logic [NUM_EXP-1:0] bitmap;
  logic [NUM_EXP-1:0] hit;
  logic [NUM_EXP-1:0] set_bit;
  logic               free_hit;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   ptr;
  logic               store_vld;
  logic               ign_hit;
  logic               do_match;
  logic               last_match;
  logic               err;
  logic [2:0]         err_code;
  logic               timeout_hit;

  mwc_exp_table #(
    .NUM_EXP (NUM_EXP),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cfg_we && (state != ST_RUN)),
    .wr_idx   (cfg_idx),
    .wr_addr  (cfg_addr),
    .wr_data  (cfg_data),
    .cmp_addr (mem.mem_addr),
    .cmp_data (mem.mem_wdata),
    .matched  (bitmap),
    .hit      (hit),
    .free_hit (free_hit),
    .free_idx (free_idx)
  );

  // In ordered mode the match count doubles as the next-expected pointer; it never
  // reaches NUM_EXP while in RUN because that transition goes straight to PASS.
  assign ptr         = match_cnt[IDX_W-1:0];
  assign store_vld   = (state == ST_RUN) && !start && mem.mem_we;
  assign ign_hit     = ((mem.mem_addr ^ ign_base) & ign_mask) == '0;
  assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT - 1));
  assign last_match  = do_match && (match_cnt == (IDX_W + 1)'(NUM_EXP - 1));

  always_comb begin
    do_match = 1'b0;
    set_bit  = '0;
    err      = 1'b0;
    err_code = FC_NONE;
    if (store_vld) begin
      if (ORDERED != 0) begin
        if (hit[ptr]) begin
          do_match     = 1'b1;
          set_bit[ptr] = 1'b1;
        end else if (|hit) begin
          err      = 1'b1;
          err_code = FC_ORDER;
        end else if (!ign_hit) begin
          err      = 1'b1;
          err_code = FC_UNEXPECTED;
        end
      end else begin
        if (free_hit) begin
          do_match          = 1'b1;
          set_bit[free_idx] = 1'b1;
        end else if (|hit) begin
          // Equal only to entries already consumed.
          err      = 1'b1;
          err_code = FC_DUP;
        end else if (!ign_hit) begin
          err      = 1'b1;
          err_code = FC_UNEXPECTED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bitmap    <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (start) begin
      state     <= ST_RUN;
      bitmap    <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state == ST_RUN) begin
      if (cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (do_match) begin
        match_cnt <= match_cnt + (IDX_W + 1)'(1);
        bitmap    <= bitmap | set_bit;
      end
      // A deciding store in the last allowed cycle takes precedence over the timeout.
      if (last_match) begin
        state <= ST_PASS;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else if (err) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        fail_code <= err_code;
        fail_addr <= mem.mem_addr;
        fail_data <= mem.mem_wdata;
      end else if (timeout_hit) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        fail_code <= FC_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic        cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [31:0] ign_base, ign_mask;
  logic        start;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) if_o ();
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) if_u ();
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) if_t ();
  assign if_o.mem_we = mem_we;  assign if_o.mem_addr = mem_addr;  assign if_o.mem_wdata = mem_wdata;
  assign if_u.mem_we = mem_we;  assign if_u.mem_addr = mem_addr;  assign if_u.mem_wdata = mem_wdata;
  assign if_t.mem_we = mem_we;  assign if_t.mem_addr = mem_addr;  assign if_t.mem_wdata = mem_wdata;

  logic o_done, o_pass, u_done, u_pass, t_done, t_pass;
  logic [2:0]  o_fc, u_fc, t_fc;
  logic [31:0] o_fa, o_fd, u_fa, u_fd, t_fa, t_fd;
  logic [1:0]  o_mc, u_mc, t_mc;
  logic [9:0]  o_cc, u_cc;
  logic [4:0]  t_cc;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .ORDERED(1), .TIMEOUT(1000)) dut_o (
    .clk(clk), .reset(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ign_base(ign_base), .ign_mask(ign_mask), .start(start), .mem(if_o),
    .done(o_done), .pass(o_pass), .fail_code(o_fc), .fail_addr(o_fa), .fail_data(o_fd),
    .match_cnt(o_mc), .cycle_cnt(o_cc));

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .ORDERED(0), .TIMEOUT(1000)) dut_u (
    .clk(clk), .reset(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ign_base(ign_base), .ign_mask(ign_mask), .start(start), .mem(if_u),
    .done(u_done), .pass(u_pass), .fail_code(u_fc), .fail_addr(u_fa), .fail_data(u_fd),
    .match_cnt(u_mc), .cycle_cnt(u_cc));

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .ORDERED(1), .TIMEOUT(20)) dut_t (
    .clk(clk), .reset(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ign_base(ign_base), .ign_mask(ign_mask), .start(start), .mem(if_t),
    .done(t_done), .pass(t_pass), .fail_code(t_fc), .fail_addr(t_fa), .fail_data(t_fd),
    .match_cnt(t_mc), .cycle_cnt(t_cc));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one per instance (0 ordered, 1 unordered, 2 ordered with short timeout).
  // Outstanding entries are a queue of table indices in ascending order.
  bit          m_ord [3] = '{1'b1, 1'b0, 1'b1};
  int          m_tmo [3] = '{1000, 1000, 20};
  int          m_sat [3] = '{1023, 1023, 31};
  int          phase [3];            // 0 idle, 1 running, 2 finished
  logic [31:0] ta [3][2];
  logic [31:0] td [3][2];
  int          rem [3][$];
  bit          e_done [3];
  bit          e_pass [3];
  logic [2:0]  e_fc [3];
  logic [31:0] e_fa [3];
  logic [31:0] e_fd [3];
  int          e_cyc [3];

  function automatic void clear_status(int d);
    rem[d].delete();
    rem[d].push_back(0);
    rem[d].push_back(1);
    e_done[d] = 0; e_pass[d] = 0; e_fc[d] = 0; e_fa[d] = 0; e_fd[d] = 0; e_cyc[d] = 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      phase[d] = 0;
      for (int i = 0; i < 2; i++) begin
        ta[d][i] = 0;
        td[d][i] = 0;
      end
      clear_status(d);
    end
  endtask

  function automatic bit eq(int d, int i);
    return (ta[d][i] == mem_addr) && (td[d][i] == mem_wdata);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        phase[d] = 0;
        for (int i = 0; i < 2; i++) begin
          ta[d][i] = 0;
          td[d][i] = 0;
        end
        clear_status(d);
      end else begin
        if (cfg_we && phase[d] != 1) begin
          ta[d][cfg_idx] = cfg_addr;
          td[d][cfg_idx] = cfg_data;
        end
        if (start) begin
          phase[d] = 1;
          clear_status(d);
        end else if (phase[d] == 1) begin
          bit matched = 0;
          bit any     = 0;
          int fc      = 0;
          bit ign     = ((mem_addr ^ ign_base) & ign_mask) == 0;
          if (mem_we) begin
            any = eq(d, 0) || eq(d, 1);
            if (m_ord[d]) begin
              if (eq(d, rem[d][0])) begin
                void'(rem[d].pop_front());
                matched = 1;
              end else if (any) fc = 2;
              else if (!ign) fc = 1;
            end else begin
              int k = -1;
              for (int j = 0; j < rem[d].size(); j++)
                if (k < 0 && eq(d, rem[d][j])) k = j;
              if (k >= 0) begin
                rem[d].delete(k);
                matched = 1;
              end else if (any) fc = 3;
              else if (!ign) fc = 1;
            end
          end
          if (matched && rem[d].size() == 0) begin
            phase[d] = 2; e_done[d] = 1; e_pass[d] = 1;
          end else if (fc != 0) begin
            phase[d] = 2; e_done[d] = 1; e_fc[d] = 3'(fc); e_fa[d] = mem_addr; e_fd[d] = mem_wdata;
          end else if (e_cyc[d] == m_tmo[d] - 1) begin
            phase[d] = 2; e_done[d] = 1; e_fc[d] = 3'd4;
          end
          if (e_cyc[d] < m_sat[d]) e_cyc[d]++;
        end
      end
    end
  endtask

  task automatic chk_dut(string nm, int d, logic dn, logic ps, logic [2:0] fc,
                         logic [31:0] fa, logic [31:0] fd, int mc, int cc);
    int emc = 2 - rem[d].size();
    n_vec++;
    if (dn !== e_done[d] || ps !== e_pass[d] || fc !== e_fc[d] || fa !== e_fa[d] ||
        fd !== e_fd[d] || mc != emc || cc != e_cyc[d]) begin
      n_err++;
      $display("FAIL %s model t=%0t got dn=%0b ps=%0b fc=%0d fa=%h fd=%h mc=%0d cc=%0d want dn=%0b ps=%0b fc=%0d fa=%h fd=%h mc=%0d cc=%0d",
               nm, $time, dn, ps, fc, fa, fd, mc, cc,
               e_done[d], e_pass[d], e_fc[d], e_fa[d], e_fd[d], emc, e_cyc[d]);
    end
  endtask

  task automatic check_all();
    chk_dut("ord", 0, o_done, o_pass, o_fc, o_fa, o_fd, int'(o_mc), int'(o_cc));
    chk_dut("unord", 1, u_done, u_pass, u_fc, u_fa, u_fd, int'(u_mc), int'(u_cc));
    chk_dut("tmo", 2, t_done, t_pass, t_fc, t_fa, t_fd, int'(t_mc), int'(t_cc));
  endtask

  task automatic chk_val(string nm, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // One clock: inputs already driven; model advances on the edge, outputs compared mid-low.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    cfg_we = 0; start = 0; mem_we = 0;
  endtask

  task automatic load(bit idx, logic [31:0] a, logic [31:0] w);
    cfg_we = 1; cfg_idx = idx; cfg_addr = a; cfg_data = w;
    cycle();
    cfg_we = 0;
  endtask

  typedef struct {
    bit          st;
    bit          we;
    logic [31:0] a;
    logic [31:0] w;
    bit          o_dn, o_ps;
    logic [2:0]  o_fc;
    logic [31:0] o_fa;
    int          o_mc;
    bit          u_dn, u_ps;
    logic [2:0]  u_fc;
    logic [31:0] u_fa;
    int          u_mc;
  } vec_t;

  function automatic vec_t mkv(bit st, bit we, logic [31:0] a, logic [31:0] w,
                               bit odn, bit ops, logic [2:0] ofc, logic [31:0] ofa, int omc,
                               bit udn, bit ups, logic [2:0] ufc, logic [31:0] ufa, int umc);
    vec_t v;
    v.st = st; v.we = we; v.a = a; v.w = w;
    v.o_dn = odn; v.o_ps = ops; v.o_fc = ofc; v.o_fa = ofa; v.o_mc = omc;
    v.u_dn = udn; v.u_ps = ups; v.u_fc = ufc; v.u_fa = ufa; v.u_mc = umc;
    return v;
  endfunction

  task automatic chk_row(string nm, int row, logic dn, logic ps, logic [2:0] fc, logic [31:0] fa,
                         int mc, bit edn, bit eps, logic [2:0] efc, logic [31:0] efa, int emc);
    n_vec++;
    if (dn !== edn || ps !== eps || fc !== efc || fa !== efa || mc != emc) begin
      n_err++;
      $display("FAIL %s row %0d got dn=%0b ps=%0b fc=%0d fa=%0d mc=%0d want dn=%0b ps=%0b fc=%0d fa=%0d mc=%0d",
               nm, row, dn, ps, fc, fa, mc, edn, eps, efc, efa, emc);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 32'd80;
      1: return 32'd84;
      2: return 32'd88;
      3: return 32'h104;
      default: return 32'h1FC;
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 4))
      0: return 32'h10;
      1: return 32'd7;
      2: return 32'd6;
      3: return 32'd5;
      default: return 32'd1;
    endcase
  endfunction

  vec_t vt [14];

  initial begin
    int first;

    rst_n = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0;
    mem_addr = 0; mem_wdata = 0;
    ign_base = 32'h100; ign_mask = 32'hFFFF_FF00;
    idle_inputs();
    model_reset();
    #12;
    check_all();                       // reset state
    cycle();
    rst_n = 1;
    load(0, 32'd80, 32'h10);
    load(1, 32'd84, 32'd7);

    //          st we addr     data   | ord: dn ps fc fa  mc | unord: dn ps fc fa  mc
    vt[0]  = mkv(1, 0, 0,       0,      0, 0, 0, 0,  0,   0, 0, 0, 0,  0);
    vt[1]  = mkv(0, 1, 80,      'h10,   0, 0, 0, 0,  1,   0, 0, 0, 0,  1);
    vt[2]  = mkv(0, 1, 'h104,   5,      0, 0, 0, 0,  1,   0, 0, 0, 0,  1);
    vt[3]  = mkv(0, 1, 84,      7,      1, 1, 0, 0,  2,   1, 1, 0, 0,  2);
    vt[4]  = mkv(1, 0, 0,       0,      0, 0, 0, 0,  0,   0, 0, 0, 0,  0);
    vt[5]  = mkv(0, 1, 84,      7,      1, 0, 2, 84, 0,   0, 0, 0, 0,  1);
    vt[6]  = mkv(0, 1, 84,      7,      1, 0, 2, 84, 0,   1, 0, 3, 84, 1);
    vt[7]  = mkv(1, 0, 0,       0,      0, 0, 0, 0,  0,   0, 0, 0, 0,  0);
    vt[8]  = mkv(0, 1, 88,      1,      1, 0, 1, 88, 0,   1, 0, 1, 88, 0);
    vt[9]  = mkv(1, 0, 0,       0,      0, 0, 0, 0,  0,   0, 0, 0, 0,  0);
    vt[10] = mkv(0, 1, 84,      6,      1, 0, 1, 84, 0,   1, 0, 1, 84, 0);
    vt[11] = mkv(1, 0, 0,       0,      0, 0, 0, 0,  0,   0, 0, 0, 0,  0);
    vt[12] = mkv(0, 1, 84,      7,      1, 0, 2, 84, 0,   0, 0, 0, 0,  1);
    vt[13] = mkv(0, 1, 80,      'h10,   1, 0, 2, 84, 0,   1, 1, 0, 0,  2);

    for (int i = 0; i < 14; i++) begin
      start = vt[i].st; mem_we = vt[i].we; mem_addr = vt[i].a; mem_wdata = vt[i].w;
      cycle();
      chk_row("row_ord", i, o_done, o_pass, o_fc, o_fa, int'(o_mc),
              vt[i].o_dn, vt[i].o_ps, vt[i].o_fc, vt[i].o_fa, vt[i].o_mc);
      chk_row("row_tmo", i, t_done, t_pass, t_fc, t_fa, int'(t_mc),
              vt[i].o_dn, vt[i].o_ps, vt[i].o_fc, vt[i].o_fa, vt[i].o_mc);
      chk_row("row_unord", i, u_done, u_pass, u_fc, u_fa, int'(u_mc),
              vt[i].u_dn, vt[i].u_ps, vt[i].u_fc, vt[i].u_fa, vt[i].u_mc);
    end
    idle_inputs();

    // Timeout: start, one match, then silence; short-timeout instance gives up 20 cycles in.
    start = 1; cycle(); start = 0;
    mem_we = 1; mem_addr = 80; mem_wdata = 'h10; cycle(); mem_we = 0;
    first = -1;
    for (int k = 2; k <= 40; k++) begin
      cycle();
      if (t_done && first < 0) first = k;
    end
    chk_val("timeout_edge", first, 20);
    chk_val("timeout_code", int'(t_fc), 4);
    chk_val("timeout_addr", int'(t_fa), 0);
    chk_val("timeout_match", int'(t_mc), 1);
    chk_val("timeout_cycles", int'(t_cc), 20);

    // A deciding store in the last allowed cycle beats the timeout.
    start = 1; cycle(); start = 0;
    for (int k = 1; k <= 19; k++) cycle();
    mem_we = 1; mem_addr = 88; mem_wdata = 1; cycle(); mem_we = 0;
    chk_val("late_store_code", int'(t_fc), 1);
    chk_val("late_store_addr", int'(t_fa), 88);

    // Asynchronous reset mid-run clears everything without a clock edge.
    start = 1; cycle(); start = 0;
    mem_we = 1; mem_addr = 80; mem_wdata = 'h10; cycle(); mem_we = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk_val("areset_match", int'(o_mc), 0);
    cycle();
    rst_n = 1;

    // cfg write with start lands; cfg write during RUN is ignored.
    load(0, 32'd80, 32'h10);
    start = 1; cfg_we = 1; cfg_idx = 1; cfg_addr = 84; cfg_data = 7;
    cycle();
    start = 0; cfg_idx = 0; cfg_addr = 200; cfg_data = 2;
    mem_we = 1; mem_addr = 80; mem_wdata = 'h10; cycle();
    cfg_we = 0; mem_addr = 84; mem_wdata = 7; cycle(); mem_we = 0;
    chk_val("cfg_start_pass", int'(o_pass), 1);
    chk_val("cfg_start_match", int'(o_mc), 2);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      start    = ($urandom_range(0, 99) < 4);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_idx  = 1'($urandom_range(0, 1));
      cfg_addr = pick_addr();
      cfg_data = pick_data();
      mem_we   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        int k = $urandom_range(0, 1);
        mem_addr = ta[0][k]; mem_wdata = td[0][k];
      end else begin
        mem_addr = pick_addr(); mem_wdata = pick_data();
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
